reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Architectural register file with rename tags.
- Sits directly downstream of the reorder buffer's commit port: it consumes the committed (dest, rd, value) triple and writes the architectural value.
- Also serves the issuer: returns either a ready value or the producing ROB id for each source operand, and records the new tag for each renamed destination.
- A flush from the ROB bus discards all pending tags.

Parameters:
- REG_COUNT, 32, number of architectural registers; x0 hardwired to zero.
- REG_ID_WIDTH, 5, register index width.
- XLEN, 32, data width.
- ROB_ID_WIDTH, 4, ROB id width; id 0 means "no producer", valid ids are 1..2^ROB_ID_WIDTH-1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- rdy  input  1  global enable; when low, all state holds
- reset_from_rob_bus  input  1  misprediction flush
- valid_from_issuer  input  1  issuer renames rd this cycle
- rd_from_issuer  input  REG_ID_WIDTH  destination being renamed
- dest_from_issuer  input  ROB_ID_WIDTH  ROB id allocated to that instruction
- rs1_from_issuer  input  REG_ID_WIDTH  source 1 index
- rs2_from_issuer  input  REG_ID_WIDTH  source 2 index
- qj_to_issuer  output  ROB_ID_WIDTH  producer of rs1, 0 if ready
- vj_to_issuer  output  XLEN  value of rs1, valid when qj=0
- qk_to_issuer  output  ROB_ID_WIDTH  producer of rs2, 0 if ready
- vk_to_issuer  output  XLEN  value of rs2, valid when qk=0
- dest_from_rob  input  ROB_ID_WIDTH  committing ROB id, 0 = no commit
- rd_from_rob  input  REG_ID_WIDTH  committed destination
- value_from_rob  input  XLEN  committed value

Behaviour:
- State: value[REG_COUNT] (XLEN bits) and tag[REG_COUNT] (ROB_ID_WIDTH bits).

Reset and enable:
- rst asserted (async) clears every value and tag to 0. The read ports are combinational and therefore output q=0, v=0 for all indices.
- rdy low: no state update; read ports remain combinational.

Commit (posedge, rdy, dest_from_rob != 0, rd_from_rob != 0):
- value[rd_from_rob] <= value_from_rob.
- If tag[rd_from_rob] == dest_from_rob, the tag is cleared to 0; otherwise the tag is kept, because a younger writer is pending.
- A commit to rd=0 is ignored entirely.

Rename (posedge, rdy, valid_from_issuer, rd_from_issuer != 0, no flush):
- tag[rd_from_issuer] <= dest_from_issuer.

Rename and commit to the same register in the same cycle:
- The value is written.
- The tag becomes dest_from_issuer; rename wins over the tag clear.

Flush (posedge, rdy, reset_from_rob_bus):
- All tags are cleared to 0; rename is ignored.
- Commit in the same cycle still writes its value, since committed work is older than the flush.

Read path (combinational, 0-cycle latency, per source rs):
- rs == 0: q=0, v=0.
- Else, if a commit is presented this cycle with rd_from_rob == rs and dest_from_rob == tag[rs]: q=0, v=value_from_rob (commit bypass).
- Else: q=tag[rs], v=value[rs].
- Sources always see state before the same-cycle rename, so an instruction never depends on itself (e.g. add x5,x5,x1 sees the old producer of x5).
- The flush signal does not alter the read outputs combinationally; the issuer discards its work during a flush.

Width and implementation rules:
- No arithmetic beyond equality compares.
- Tag width is exactly ROB_ID_WIDTH; id 0 is never issued by the ROB.
- Target size: roughly 120–180 lines of RTL (register arrays, one always block with async reset, two read muxes).

Test Plan:
- Reset: assert rst mid-cycle with tag[3]=5 and value[3]=0x11 -> immediately q/v for x3 read 0/0 before the next clk edge.
- Rename then commit: rename x7->ROB 2; read rs1=7 gives qj=2. Next cycle commit (dest=2, rd=7, value=0xDEAD) -> same cycle qj=0, vj=0xDEAD (bypass); after the edge, tag[7]=0 and value[7]=0xDEAD.
- Stale commit: rename x4->3, then x4->6. Commit (dest=3, rd=4, value=0x55) -> value[4]=0x55 but tag[4] stays 6; read gives qk=6.
- Simultaneous events: same cycle rename x9->8 and commit (dest=4, rd=9) while tag[9]=4 -> tag[9]=8 and value written. Same cycle rs1=9 reads qj=0 with the committed value.
- Flush: tags x1=2, x2=3. Assert reset_from_rob_bus together with commit (dest=2, rd=1, value=0x77) and rename x5->4 -> all tags 0, value[1]=0x77, tag[5]=0.
- x0 and rdy: rename x0->5 and commit rd=0 value 0xFF -> reads of x0 stay q=0, v=0. With rdy=0, a rename of x3->1 leaves tag[3] unchanged.

Source files
------------

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Commit writes values, rename records producer ROB ids, and reads bypass a same-cycle commit.
module reg_file #(
  parameter int REG_COUNT    = 32,
  parameter int REG_ID_WIDTH = 5,
  parameter int XLEN         = 32,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    reset_from_rob_bus,
  input  logic                    valid_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rd_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rs1_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rs2_from_issuer,
  output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
  output logic [XLEN-1:0]         vj_to_issuer,
  output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
  output logic [XLEN-1:0]         vk_to_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
  input  logic [REG_ID_WIDTH-1:0] rd_from_rob,
  input  logic [XLEN-1:0]         value_from_rob
);

  logic [XLEN-1:0]         value [REG_COUNT];
  logic [ROB_ID_WIDTH-1:0] tag   [REG_COUNT];

  logic commit_valid;
  logic rename_valid;

  // A commit or rename aimed at x0 never touches state, which keeps x0 reading zero.
  assign commit_valid = (dest_from_rob != '0) && (rd_from_rob != '0);
  assign rename_valid = valid_from_issuer && (rd_from_issuer != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the arrays are flops, not RAM, so they can and must be reset; the
      // read ports expose them combinationally and must show zero straight out of reset.
      for (int i = 0; i < REG_COUNT; i++) begin
        value[i] <= '0;
        tag[i]   <= '0;
      end
    end else if (rdy) begin
      if (commit_valid) begin
        value[rd_from_rob] <= value_from_rob;
        if (tag[rd_from_rob] == dest_from_rob)
          tag[rd_from_rob] <= '0;
      end
      // NOTE: with non-blocking assignments the last write to a tag in this block
      // wins, so statement order sets priority: flush over rename over commit clear.
      if (reset_from_rob_bus) begin
        for (int i = 0; i < REG_COUNT; i++)
          tag[i] <= '0;
      end else if (rename_valid) begin
        tag[rd_from_issuer] <= dest_from_issuer;
      end
    end
  end

  // Reads see pre-rename state; a matching commit in flight is forwarded as ready.
  function automatic logic [ROB_ID_WIDTH+XLEN-1:0] read_port(
    input logic [REG_ID_WIDTH-1:0] rs
  );
    logic [ROB_ID_WIDTH-1:0] q;
    logic [XLEN-1:0]         v;
    q = tag[rs];
    v = value[rs];
    if (rs == '0) begin
      q = '0;
      v = '0;
    end else if ((dest_from_rob != '0) && (rd_from_rob == rs) && (dest_from_rob == tag[rs])) begin
      q = '0;
      v = value_from_rob;
    end
    return {q, v};
  endfunction

  assign {qj_to_issuer, vj_to_issuer} = read_port(rs1_from_issuer);
  assign {qk_to_issuer, vk_to_issuer} = read_port(rs2_from_issuer);

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expected read results are queued as each stimulus
// is applied, then popped and compared against the combinational read ports.
module tb_reg_file;

  localparam int RW = 5;
  localparam int XL = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          reset_from_rob_bus;
  logic          valid_from_issuer;
  logic [RW-1:0] rd_from_issuer;
  logic [TW-1:0] dest_from_issuer;
  logic [RW-1:0] rs1_from_issuer;
  logic [RW-1:0] rs2_from_issuer;
  logic [TW-1:0] qj_to_issuer;
  logic [XL-1:0] vj_to_issuer;
  logic [TW-1:0] qk_to_issuer;
  logic [XL-1:0] vk_to_issuer;
  logic [TW-1:0] dest_from_rob;
  logic [RW-1:0] rd_from_rob;
  logic [XL-1:0] value_from_rob;

  typedef struct packed {
    logic [TW-1:0] q;
    logic [XL-1:0] v;
  } exp_t;

  exp_t sb [$];
  int   checks   = 0;
  int   failures = 0;

  reg_file dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .reset_from_rob_bus (reset_from_rob_bus),
    .valid_from_issuer  (valid_from_issuer),
    .rd_from_issuer     (rd_from_issuer),
    .dest_from_issuer   (dest_from_issuer),
    .rs1_from_issuer    (rs1_from_issuer),
    .rs2_from_issuer    (rs2_from_issuer),
    .qj_to_issuer       (qj_to_issuer),
    .vj_to_issuer       (vj_to_issuer),
    .qk_to_issuer       (qk_to_issuer),
    .vk_to_issuer       (vk_to_issuer),
    .dest_from_rob      (dest_from_rob),
    .rd_from_rob        (rd_from_rob),
    .value_from_rob     (value_from_rob)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic idle();
    valid_from_issuer  = 1'b0;
    rd_from_issuer     = '0;
    dest_from_issuer   = '0;
    reset_from_rob_bus = 1'b0;
    dest_from_rob      = '0;
    rd_from_rob        = '0;
    value_from_rob     = '0;
  endtask

  task automatic rename(input logic [RW-1:0] rd, input logic [TW-1:0] id);
    valid_from_issuer = 1'b1;
    rd_from_issuer    = rd;
    dest_from_issuer  = id;
  endtask

  task automatic commit(input logic [TW-1:0] id, input logic [RW-1:0] rd, input logic [XL-1:0] val);
    dest_from_rob  = id;
    rd_from_rob    = rd;
    value_from_rob = val;
  endtask

  // Apply an edge, then return just after the falling edge with stimulus idle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  // Queue the expected operands, let the read path settle, then compare.
  task automatic read(input string name, input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                      input logic [TW-1:0] eqj, input logic [XL-1:0] evj,
                      input logic [TW-1:0] eqk, input logic [XL-1:0] evk);
    exp_t e;
    rs1_from_issuer = r1;
    rs2_from_issuer = r2;
    sb.push_back('{q: eqj, v: evj});
    sb.push_back('{q: eqk, v: evk});
    #1;
    e = sb.pop_front();
    check({name, ".qj"}, 64'(qj_to_issuer), 64'(e.q));
    check({name, ".vj"}, 64'(vj_to_issuer), 64'(e.v));
    e = sb.pop_front();
    check({name, ".qk"}, 64'(qk_to_issuer), 64'(e.q));
    check({name, ".vk"}, 64'(vk_to_issuer), 64'(e.v));
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    rs1_from_issuer = '0;
    rs2_from_issuer = '0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    read("reset_state", 5'd3, 5'd31, 4'd0, 32'h0, 4'd0, 32'h0);

    // Set up tag[3]=5, value[3]=0x11 via a non-matching commit.
    rename(5'd3, 4'd5);
    tick();
    commit(4'd1, 5'd3, 32'h11);
    read("stale_no_bypass", 5'd3, 5'd0, 4'd5, 32'h0, 4'd0, 32'h0);
    tick();
    read("pre_reset", 5'd3, 5'd0, 4'd5, 32'h11, 4'd0, 32'h0);

    // Asynchronous reset mid-cycle clears reads before any edge.
    #1;
    rst = 1'b1;
    read("async_reset", 5'd3, 5'd3, 4'd0, 32'h0, 4'd0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Rename then commit with bypass.
    rename(5'd7, 4'd2);
    read("rename_self", 5'd7, 5'd0, 4'd0, 32'h0, 4'd0, 32'h0);
    tick();
    read("renamed", 5'd7, 5'd0, 4'd2, 32'h0, 4'd0, 32'h0);
    commit(4'd2, 5'd7, 32'hDEAD);
    read("bypass", 5'd7, 5'd7, 4'd0, 32'hDEAD, 4'd0, 32'hDEAD);
    tick();
    read("committed", 5'd7, 5'd0, 4'd0, 32'hDEAD, 4'd0, 32'h0);

    // Stale commit keeps the younger tag.
    rename(5'd4, 4'd3);
    tick();
    rename(5'd4, 4'd6);
    tick();
    commit(4'd3, 5'd4, 32'h55);
    read("stale_cycle", 5'd0, 5'd4, 4'd0, 32'h0, 4'd6, 32'h0);
    tick();
    read("stale_after", 5'd0, 5'd4, 4'd0, 32'h0, 4'd6, 32'h55);

    // Rename and commit to the same register together.
    rename(5'd9, 4'd4);
    tick();
    rename(5'd9, 4'd8);
    commit(4'd4, 5'd9, 32'h99);
    read("simul_cycle", 5'd9, 5'd9, 4'd0, 32'h99, 4'd0, 32'h99);
    tick();
    read("simul_after", 5'd9, 5'd0, 4'd8, 32'h99, 4'd0, 32'h0);

    // Flush with a same-cycle commit and rename.
    rename(5'd1, 4'd2);
    tick();
    rename(5'd2, 4'd3);
    tick();
    read("pre_flush", 5'd1, 5'd2, 4'd2, 32'h0, 4'd3, 32'h0);
    reset_from_rob_bus = 1'b1;
    commit(4'd2, 5'd1, 32'h77);
    rename(5'd5, 4'd4);
    read("flush_cycle", 5'd1, 5'd5, 4'd0, 32'h77, 4'd0, 32'h0);
    tick();
    read("flush_x1_x2", 5'd1, 5'd2, 4'd0, 32'h77, 4'd0, 32'h0);
    read("flush_x4_x9", 5'd4, 5'd9, 4'd0, 32'h55, 4'd0, 32'h99);
    read("flush_x5", 5'd5, 5'd0, 4'd0, 32'h0, 4'd0, 32'h0);

    // x0 stays zero under rename and commit.
    rename(5'd0, 4'd5);
    commit(4'd5, 5'd0, 32'hFF);
    read("x0_cycle", 5'd0, 5'd0, 4'd0, 32'h0, 4'd0, 32'h0);
    tick();
    read("x0_after", 5'd0, 5'd0, 4'd0, 32'h0, 4'd0, 32'h0);

    // dest 0 means no commit: no bypass against a zero tag, no write.
    commit(4'd0, 5'd3, 32'hCC);
    read("dest0_cycle", 5'd3, 5'd0, 4'd0, 32'h0, 4'd0, 32'h0);
    tick();
    read("dest0_after", 5'd3, 5'd0, 4'd0, 32'h0, 4'd0, 32'h0);

    // rdy low holds all state.
    rdy = 1'b0;
    rename(5'd3, 4'd1);
    commit(4'd7, 5'd6, 32'hAB);
    tick();
    rdy = 1'b1;
    read("rdy_hold", 5'd3, 5'd6, 4'd0, 32'h0, 4'd0, 32'h0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
